signed_division_controller: RTL and testbench

SIGNED_DIVISION_CONTROLLER -- requirements
Module: signed_division_controller

---
 rtl/signed_division_controller_pkg.sv | 21 ++
 rtl/signed_division_controller_twos_complement_abs.sv | 15 +
 rtl/signed_division_controller.sv | 131 +++++++++++++
 tb/tb_signed_division_controller.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/signed_division_controller_pkg.sv
// Shared types for the signed division controller: FSM state encoding and the
// packed result record. Fields are sized for the widest supported operand.
package signed_division_controller_pkg;

  localparam int RES_MAX_W = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_FIXUP,
    ST_OUTPUT
  } state_e;

  typedef struct packed {
    logic                 divide_by_zero;
    logic [RES_MAX_W-1:0] remainder;
    logic [RES_MAX_W-1:0] quotient;
  } result_t;

endpackage

// File: rtl/signed_division_controller_twos_complement_abs.sv
// Conditional two's-complement negate; combinational, no backpressure.
// Negating the most negative value wraps back to itself.
module twos_complement_abs
  import signed_division_controller_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  negate,
  output logic [DATA_WIDTH-1:0] result
);

  assign result = negate ? ((~data) + DATA_WIDTH'(1)) : data;

endmodule

// File: rtl/signed_division_controller.sv
// Signed/unsigned wrapper around an external unsigned divider; latency is 1 + divider + 2 cycles, or 1 cycle for special cases.
// Single request in flight: ready_o only in IDLE, and the result is held in OUTPUT until ready_i.
module signed_division_controller
  import signed_division_controller_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] dividend_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  input  logic                  signed_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] quotient_o,
  output logic [DATA_WIDTH-1:0] remainder_o,
  output logic                  divide_by_zero_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] div_dividend_o,
  output logic [DATA_WIDTH-1:0] div_divisor_o,
  output logic                  div_start_o,
  input  logic [DATA_WIDTH-1:0] div_quotient_i,
  input  logic [DATA_WIDTH-1:0] div_remainder_i,
  input  logic                  div_valid_i,
  input  logic                  div_idle_i
);

  localparam logic [DATA_WIDTH-1:0] MIN_NEG  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] ALL_ONES = '1;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] dividend_q, divisor_q;
  logic [DATA_WIDTH-1:0] quo_raw_q, rem_raw_q;
  logic [DATA_WIDTH-1:0] quo_fix, rem_fix;
  logic                  signed_q, dvd_neg_q, dvs_neg_q;
  result_t               result_q;
  logic                  accept, is_zero, is_ovf;

  assign ready_o = (state_q == ST_IDLE);
  assign valid_o = (state_q == ST_OUTPUT);
  assign accept  = valid_i & ready_o;
  assign is_zero = (divisor_i == '0);
  assign is_ovf  = signed_i & (dividend_i == MIN_NEG) & (divisor_i == ALL_ONES);

  twos_complement_abs #(.DATA_WIDTH(DATA_WIDTH)) u_abs_dividend (
    .data(dividend_q), .negate(signed_q & dvd_neg_q), .result(div_dividend_o)
  );
  twos_complement_abs #(.DATA_WIDTH(DATA_WIDTH)) u_abs_divisor (
    .data(divisor_q), .negate(signed_q & dvs_neg_q), .result(div_divisor_o)
  );
  twos_complement_abs #(.DATA_WIDTH(DATA_WIDTH)) u_fix_quotient (
    .data(quo_raw_q), .negate(signed_q & (dvd_neg_q ^ dvs_neg_q)), .result(quo_fix)
  );
  twos_complement_abs #(.DATA_WIDTH(DATA_WIDTH)) u_fix_remainder (
    .data(rem_raw_q), .negate(signed_q & dvd_neg_q), .result(rem_fix)
  );

  always_comb begin
    state_d     = state_q;
    div_start_o = 1'b0;
    case (state_q)
      ST_IDLE:   if (valid_i) state_d = (is_zero | is_ovf) ? ST_OUTPUT : ST_ISSUE;
      ST_ISSUE: begin
        if (div_idle_i) begin
          div_start_o = 1'b1;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT:   if (div_valid_i) state_d = ST_FIXUP;
      ST_FIXUP:  state_d = ST_OUTPUT;
      ST_OUTPUT: if (ready_i) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      dividend_q <= '0;
      divisor_q  <= '0;
      signed_q   <= 1'b0;
      dvd_neg_q  <= 1'b0;
      dvs_neg_q  <= 1'b0;
      quo_raw_q  <= '0;
      rem_raw_q  <= '0;
      result_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        dividend_q <= dividend_i;
        divisor_q  <= divisor_i;
        signed_q   <= signed_i;
        dvd_neg_q  <= dividend_i[DATA_WIDTH-1];
        dvs_neg_q  <= divisor_i[DATA_WIDTH-1];
        // Special cases bypass the divider and are resolved right here.
        if (is_zero) begin
          result_q.divide_by_zero <= 1'b1;
          result_q.quotient       <= RES_MAX_W'(ALL_ONES);
          result_q.remainder      <= RES_MAX_W'(dividend_i);
        end else if (is_ovf) begin
          result_q.divide_by_zero <= 1'b0;
          result_q.quotient       <= RES_MAX_W'(dividend_i);
          result_q.remainder      <= '0;
        end
      end
      if ((state_q == ST_WAIT) && div_valid_i) begin
        quo_raw_q <= div_quotient_i;
        rem_raw_q <= div_remainder_i;
      end
      if (state_q == ST_FIXUP) begin
        result_q.divide_by_zero <= 1'b0;
        result_q.quotient       <= RES_MAX_W'(quo_fix);
        result_q.remainder      <= RES_MAX_W'(rem_fix);
      end
    end
  end

  assign quotient_o       = result_q.quotient[DATA_WIDTH-1:0];
  assign remainder_o      = result_q.remainder[DATA_WIDTH-1:0];
  assign divide_by_zero_o = result_q.divide_by_zero;

  generate
    if (DATA_WIDTH < RES_MAX_W) begin : g_res_hi
      logic unused_res_hi;
      assign unused_res_hi = ^{result_q.remainder[RES_MAX_W-1:DATA_WIDTH],
                               result_q.quotient[RES_MAX_W-1:DATA_WIDTH]};
    end
  endgenerate

endmodule

// File: tb/tb_signed_division_controller.sv
// Directed bench for signed_division_controller with an 18-cycle unsigned divider model.
module tb_signed_division_controller;

  localparam int W       = 16;
  localparam int DIV_LAT = 18;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic [W-1:0] dividend_i = '0;
  logic [W-1:0] divisor_i = '0;
  logic         signed_i = 1'b0;
  logic         valid_i = 1'b0;
  logic         ready_o;
  logic [W-1:0] quotient_o, remainder_o;
  logic         divide_by_zero_o;
  logic         valid_o;
  logic         ready_i = 1'b0;
  logic [W-1:0] div_dividend_o, div_divisor_o;
  logic         div_start_o;
  logic [W-1:0] div_quotient_i = '0;
  logic [W-1:0] div_remainder_i = '0;
  logic         div_valid_i = 1'b0;
  logic         div_idle_i;

  logic busy = 1'b0;
  logic idle_hold = 1'b0;
  int   cnt = 0;
  int   start_cnt = 0;
  int   errors = 0;
  int   checks = 0;

  signed_division_controller #(.DATA_WIDTH(W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .dividend_i(dividend_i), .divisor_i(divisor_i), .signed_i(signed_i),
    .valid_i(valid_i), .ready_o(ready_o),
    .quotient_o(quotient_o), .remainder_o(remainder_o),
    .divide_by_zero_o(divide_by_zero_o), .valid_o(valid_o), .ready_i(ready_i),
    .div_dividend_o(div_dividend_o), .div_divisor_o(div_divisor_o),
    .div_start_o(div_start_o), .div_quotient_i(div_quotient_i),
    .div_remainder_i(div_remainder_i), .div_valid_i(div_valid_i),
    .div_idle_i(div_idle_i)
  );

  always #5 clk_i = ~clk_i;

  // External unsigned divider: result pulse appears DIV_LAT cycles after the start cycle.
  assign div_idle_i = ~busy & ~idle_hold;
  always @(posedge clk_i) begin
    div_valid_i <= 1'b0;
    if (div_start_o === 1'b1) begin
      start_cnt <= start_cnt + 1;
      busy      <= 1'b1;
      cnt       <= DIV_LAT - 1;
      if (div_divisor_o == '0) begin
        div_quotient_i  <= '1;
        div_remainder_i <= div_dividend_o;
      end else begin
        div_quotient_i  <= div_dividend_o / div_divisor_o;
        div_remainder_i <= div_dividend_o % div_divisor_o;
      end
    end else if (busy) begin
      if (cnt == 1) begin
        div_valid_i <= 1'b1;
        busy        <= 1'b0;
      end else begin
        cnt <= cnt - 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input logic [15:0] eq, input logic [15:0] er,
                        input logic ez, input int exp_starts, input int exp_lat,
                        input int hold, input int idle_delay);
    int n;
    int st0;
    @(negedge clk_i);
    chk({tag, ".ready"}, 16'(ready_o), 16'd1);
    st0        = start_cnt;
    dividend_i = a;
    divisor_i  = b;
    signed_i   = s;
    valid_i    = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b0;
    if (idle_delay > 0) begin
      repeat (idle_delay) begin
        chk({tag, ".no_start_busy"}, 16'(div_start_o), 16'd0);
        @(negedge clk_i);
      end
      idle_hold = 1'b0;
    end
    n = 0;
    while (valid_o !== 1'b1 && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    chk({tag, ".valid"}, 16'(valid_o), 16'd1);
    if (exp_lat >= 0) chk({tag, ".latency"}, 16'(n), 16'(exp_lat));
    chk({tag, ".quotient"}, quotient_o, eq);
    chk({tag, ".remainder"}, remainder_o, er);
    chk({tag, ".dbz"}, 16'(divide_by_zero_o), 16'(ez));
    chk({tag, ".starts"}, 16'(start_cnt - st0), 16'(exp_starts));
    repeat (hold) begin
      @(negedge clk_i);
      chk({tag, ".hold_valid"}, 16'(valid_o), 16'd1);
      chk({tag, ".hold_q"}, quotient_o, eq);
      chk({tag, ".hold_r"}, remainder_o, er);
      chk({tag, ".hold_ready"}, 16'(ready_o), 16'd0);
    end
    ready_i = 1'b1;
    @(negedge clk_i);
    ready_i = 1'b0;
    chk({tag, ".released"}, 16'(valid_o), 16'd0);
    chk({tag, ".ready_again"}, 16'(ready_o), 16'd1);
  endtask

  initial begin
    int late_valid;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    chk("rst.valid", 16'(valid_o), 16'd0);
    chk("rst.ready", 16'(ready_o), 16'd1);
    chk("rst.start", 16'(div_start_o), 16'd0);
    chk("rst.dbz", 16'(divide_by_zero_o), 16'd0);
    chk("rst.q", quotient_o, 16'h0000);
    chk("rst.r", remainder_o, 16'h0000);

    run_op("s_m7_d2",   16'hFFF9, 16'h0002, 1'b1, 16'hFFFD, 16'hFFFF, 1'b0, 1, 20, 0, 0);
    run_op("s_7_dm2",   16'h0007, 16'hFFFE, 1'b1, 16'hFFFD, 16'h0001, 1'b0, 1, 20, 0, 0);
    run_op("u_ffff_d2", 16'hFFFF, 16'h0002, 1'b0, 16'h7FFF, 16'h0001, 1'b0, 1, 20, 0, 0);
    run_op("s_5_d0",    16'h0005, 16'h0000, 1'b1, 16'hFFFF, 16'h0005, 1'b1, 0, 0, 0, 0);
    run_op("u_5_d0",    16'h0005, 16'h0000, 1'b0, 16'hFFFF, 16'h0005, 1'b1, 0, 0, 0, 0);
    run_op("s_ovf",     16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'h0000, 1'b0, 0, 0, 0, 0);
    run_op("u_8000_ff", 16'h8000, 16'hFFFF, 1'b0, 16'h0000, 16'h8000, 1'b0, 1, 20, 0, 0);
    run_op("s_min_d2",  16'h8000, 16'h0002, 1'b1, 16'hC000, 16'h0000, 1'b0, 1, 20, 0, 0);
    run_op("s_m100_m7", 16'hFF9C, 16'hFFF9, 1'b1, 16'h000E, 16'hFFFE, 1'b0, 1, 20, 0, 0);
    run_op("hold10",    16'h0064, 16'h0007, 1'b1, 16'h000E, 16'h0002, 1'b0, 1, 20, 10, 0);
    idle_hold = 1'b1;
    run_op("idle_wait", 16'h0064, 16'h0007, 1'b0, 16'h000E, 16'h0002, 1'b0, 1, -1, 0, 6);

    // Reset while waiting on the divider; its late result must be dropped.
    @(negedge clk_i);
    dividend_i = 16'h0064;
    divisor_i  = 16'h0007;
    signed_i   = 1'b1;
    valid_i    = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b0;
    repeat (5) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("midrst.valid", 16'(valid_o), 16'd0);
    chk("midrst.ready", 16'(ready_o), 16'd1);
    chk("midrst.q", quotient_o, 16'h0000);
    late_valid = 0;
    repeat (30) begin
      @(negedge clk_i);
      if (valid_o !== 1'b0) late_valid++;
    end
    chk("midrst.no_output", 16'(late_valid), 16'd0);
    run_op("after_rst", 16'h03E8, 16'h000A, 1'b0, 16'h0064, 16'h0000, 1'b0, 1, 20, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
